first_nios2_system_sysid_checker: RTL and testbench



---
 rtl/sysid_pkg.sv | 22 ++
 rtl/sysid_chk_timeout.sv | 35 +++
 rtl/first_nios2_system_sysid_checker.sv | 153 +++++++++++++++
 tb/tb_first_nios2_system_sysid_checker.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sysid_pkg.sv
// Shared types and constants for the system ID checker: FSM state encoding,
// sysid word addresses and the data word width.
package sysid_pkg;

  localparam int SYSID_WORD_W = 32;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_ID  = 2'd1,
    ST_RD_TS  = 2'd2,
    ST_FINISH = 2'd3
  } sysid_chk_state_t;

  function automatic logic word_mismatch(input logic [SYSID_WORD_W-1:0] got,
                                         input logic [SYSID_WORD_W-1:0] want);
    return got != want;
  endfunction

endpackage

// File: rtl/sysid_chk_timeout.sv
// Wait-state counter for one Avalon read: counts stalled cycles, saturates at
// TIMEOUT_CYCLES and flags expiry.
module sysid_chk_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (inc && (count_q != LIMIT))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/first_nios2_system_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words,
// compares them against build-time values and reports a registered verdict.
module first_nios2_system_sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [SYSID_WORD_W-1:0] EXPECTED_ID        = 32'd0,
  parameter logic [SYSID_WORD_W-1:0] EXPECTED_TIMESTAMP = 32'd1361528575,
  parameter int                      TIMEOUT_CYCLES     = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  output logic                    avm_read,
  output logic                    avm_address,
  input  logic [SYSID_WORD_W-1:0] avm_readdata,
  input  logic                    avm_waitrequest,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    id_mismatch,
  output logic                    ts_mismatch,
  output logic                    timeout,
  output logic [SYSID_WORD_W-1:0] captured_id,
  output logic [SYSID_WORD_W-1:0] captured_ts
);

  sysid_chk_state_t state_q, state_d;
  logic read_q, read_d, addr_q, addr_d, busy_q, busy_d, done_q, done_d;
  logic pass_q, pass_d, id_mm_q, id_mm_d, ts_mm_q, ts_mm_d, tmo_q, tmo_d;
  logic [SYSID_WORD_W-1:0] cap_id_q, cap_id_d, cap_ts_q, cap_ts_d;
  logic cnt_clear, cnt_inc, cnt_expired, accept, ts_mm_now;

  assign accept    = read_q && !avm_waitrequest;
  assign cnt_inc   = read_q && avm_waitrequest;
  assign ts_mm_now = word_mismatch(avm_readdata, EXPECTED_TIMESTAMP);

  sysid_chk_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .inc    (cnt_inc),
    .expired(cnt_expired)
  );

  always_comb begin
    state_d   = state_q;
    read_d    = read_q;
    addr_d    = addr_q;
    done_d    = done_q;
    pass_d    = pass_q;
    id_mm_d   = id_mm_q;
    ts_mm_d   = ts_mm_q;
    tmo_d     = tmo_q;
    cap_id_d  = cap_id_q;
    cap_ts_d  = cap_ts_q;
    cnt_clear = 1'b0;

    case (state_q)
      ST_IDLE, ST_FINISH: begin
        if (start) begin
          state_d   = ST_RD_ID;
          read_d    = 1'b1;
          addr_d    = SYSID_ADDR_ID;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          id_mm_d   = 1'b0;
          ts_mm_d   = 1'b0;
          tmo_d     = 1'b0;
          cap_id_d  = '0;
          cap_ts_d  = '0;
          cnt_clear = 1'b1;
        end
      end
      ST_RD_ID: begin
        if (accept) begin
          cap_id_d  = avm_readdata;
          id_mm_d   = word_mismatch(avm_readdata, EXPECTED_ID);
          state_d   = ST_RD_TS;
          addr_d    = SYSID_ADDR_TS;
          cnt_clear = 1'b1;
        end else if (cnt_expired) begin
          tmo_d   = 1'b1;
          read_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          state_d = ST_FINISH;
        end
      end
      ST_RD_TS: begin
        if (accept) begin
          cap_ts_d  = avm_readdata;
          ts_mm_d   = ts_mm_now;
          read_d    = 1'b0;
          done_d    = 1'b1;
          pass_d    = !(id_mm_q || ts_mm_now || tmo_q);
          state_d   = ST_FINISH;
          cnt_clear = 1'b1;
        end else if (cnt_expired) begin
          tmo_d   = 1'b1;
          read_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          state_d = ST_FINISH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RD_ID) || (state_d == ST_RD_TS);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      read_q   <= 1'b0;
      addr_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      id_mm_q  <= 1'b0;
      ts_mm_q  <= 1'b0;
      tmo_q    <= 1'b0;
      cap_id_q <= '0;
      cap_ts_q <= '0;
    end else begin
      state_q  <= state_d;
      read_q   <= read_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      id_mm_q  <= id_mm_d;
      ts_mm_q  <= ts_mm_d;
      tmo_q    <= tmo_d;
      cap_id_q <= cap_id_d;
      cap_ts_q <= cap_ts_d;
    end
  end

  assign avm_read    = read_q;
  assign avm_address = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_mismatch = id_mm_q;
  assign ts_mismatch = ts_mm_q;
  assign timeout     = tmo_q;
  assign captured_id = cap_id_q;
  assign captured_ts = cap_ts_q;

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Bench for the sysid checker: behavioural Avalon slave with programmable
// wait states, expected verdicts queued at start and compared at done.
module tb_first_nios2_system_sysid_checker;

  localparam int          T_CYC  = 4;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1361528575;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_read, avm_address, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
  logic [31:0] captured_id, captured_ts;

  // slave model state
  logic [31:0] slv_id = 32'd0;
  logic [31:0] slv_ts = 32'd0;
  int          slv_ws = 0;
  logic        slv_stuck = 1'b0;
  int          ws_cnt = 0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          done_cyc;
    logic        pass, id_mm, ts_mm, tmo;
    logic [31:0] cap_id, cap_ts;
    int          rd0, rd1;
  } exp_t;
  exp_t sb_q[$];

  first_nios2_system_sysid_checker #(
    .EXPECTED_ID       (EXP_ID),
    .EXPECTED_TIMESTAMP(EXP_TS),
    .TIMEOUT_CYCLES    (T_CYC)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .avm_read       (avm_read),
    .avm_address    (avm_address),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .id_mismatch    (id_mismatch),
    .ts_mismatch    (ts_mismatch),
    .timeout        (timeout),
    .captured_id    (captured_id),
    .captured_ts    (captured_ts)
  );

  always #5 clock = ~clock;

  assign avm_waitrequest = slv_stuck || (ws_cnt < slv_ws);
  assign avm_readdata    = avm_address ? slv_ts : slv_id;

  always @(posedge clock) begin
    if (!avm_read || !avm_waitrequest)
      ws_cnt <= 0;
    else
      ws_cnt <= ws_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_read"},   32'(avm_read), 32'd0);
    check({pfx, "_addr"},   32'(avm_address), 32'd0);
    check({pfx, "_busy"},   32'(busy), 32'd0);
    check({pfx, "_done"},   32'(done), 32'd0);
    check({pfx, "_pass"},   32'(pass), 32'd0);
    check({pfx, "_idmm"},   32'(id_mismatch), 32'd0);
    check({pfx, "_tsmm"},   32'(ts_mismatch), 32'd0);
    check({pfx, "_tmo"},    32'(timeout), 32'd0);
    check({pfx, "_cap_id"}, captured_id, 32'd0);
    check({pfx, "_cap_ts"}, captured_ts, 32'd0);
  endtask

  // Pushes the model's verdict, pulses start, watches the bus until done.
  task automatic run_seq(input string tag, input logic [31:0] id, input logic [31:0] ts,
                         input int ws, input logic stuck, input int extra_start_cyc);
    exp_t e, g;
    int   cyc;
    slv_id    = id;
    slv_ts    = ts;
    slv_ws    = ws;
    slv_stuck = stuck;
    e.tmo      = stuck;
    e.id_mm    = stuck ? 1'b0 : (id != EXP_ID);
    e.ts_mm    = stuck ? 1'b0 : (ts != EXP_TS);
    e.cap_id   = stuck ? 32'd0 : id;
    e.cap_ts   = stuck ? 32'd0 : ts;
    e.pass     = !(e.id_mm || e.ts_mm || e.tmo);
    e.done_cyc = stuck ? T_CYC + 2 : 3 + 2 * ws;
    e.rd0      = stuck ? T_CYC + 1 : ws + 1;
    e.rd1      = stuck ? 0 : ws + 1;
    sb_q.push_back(e);

    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    cyc = 1;
    g.rd0 = 0;
    g.rd1 = 0;
    g.done_cyc = -1;
    check({tag, "_busy_c1"}, 32'(busy), 32'd1);
    while (cyc <= 60) begin
      if (avm_read) begin
        if (avm_address) g.rd1++;
        else             g.rd0++;
      end
      if (done) begin
        g.done_cyc = cyc;
        break;
      end
      if (cyc == extra_start_cyc) start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      cyc++;
    end

    e = sb_q.pop_front();
    check({tag, "_done_cyc"}, 32'(g.done_cyc), 32'(e.done_cyc));
    check({tag, "_pass"},     32'(pass), 32'(e.pass));
    check({tag, "_idmm"},     32'(id_mismatch), 32'(e.id_mm));
    check({tag, "_tsmm"},     32'(ts_mismatch), 32'(e.ts_mm));
    check({tag, "_tmo"},      32'(timeout), 32'(e.tmo));
    check({tag, "_cap_id"},   captured_id, e.cap_id);
    check({tag, "_cap_ts"},   captured_ts, e.cap_ts);
    check({tag, "_rd0_cyc"},  32'(g.rd0), 32'(e.rd0));
    check({tag, "_rd1_cyc"},  32'(g.rd1), 32'(e.rd1));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_read_end"}, 32'(avm_read), 32'd0);

    repeat (2) @(posedge clock);
    #1;
    check({tag, "_done_sticky"}, 32'(done), 32'd1);
    check({tag, "_idle_read"},   32'(avm_read), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("rst");
    @(negedge clock);
    reset = 1'b0;

    run_seq("nominal", EXP_ID, EXP_TS, 0, 1'b0, 0);
    run_seq("id_bad", 32'd1, EXP_TS, 0, 1'b0, 0);
    run_seq("ts_bad", EXP_ID, 32'hDEAD_BEEF, 0, 1'b0, 0);
    run_seq("ws3", EXP_ID, EXP_TS, 3, 1'b0, 0);
    run_seq("ws1_both_bad", 32'hFFFF_FFFF, 32'd0, 1, 1'b0, 0);
    run_seq("stuck", EXP_ID, EXP_TS, 0, 1'b1, 0);
    run_seq("recover", EXP_ID, EXP_TS, 0, 1'b0, 0);
    run_seq("start_in_ts", EXP_ID, EXP_TS, 0, 1'b0, 2);

    // Abort during the timestamp read after a mismatching ID has been captured.
    slv_id    = 32'd1;
    slv_ts    = EXP_TS;
    slv_ws    = 3;
    slv_stuck = 1'b0;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("pre_rst_cap_id", captured_id, 32'd1);
    check("pre_rst_addr",   32'(avm_address), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clock);
    #1;
    check_all_zero("abort");
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clock);
    #1;
    check("post_rst_busy", 32'(busy), 32'd0);

    run_seq("after_abort", EXP_ID, EXP_TS, 2, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
